rp_loop_ctrl: RTL and testbench

Loop-sequencing controller that drives the repeat-pointer register's strobes (write-enable, increment, rewind-to-base) directly upstream of it.
- Accepts a loop command of iteration count and body length.
- Advances the pointer once per accepted processor step.
- Rewinds the pointer to its base at the end of each non-final iteration.
- Signals completion with a one-cycle done pulse.
- Sits between the control unit's step/command decode and the pointer register.

---
 rtl/rp_loop_ctrl_pkg.sv | 15 +
 rtl/rp_step_counter.sv | 39 +++
 rtl/rp_loop_ctrl.sv | 154 +++++++++++++++
 tb/tb_rp_loop_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rp_loop_ctrl_pkg.sv
// Shared definitions for the repeat-pointer loop controller, pointer register
// and control unit.
package rp_loop_ctrl_pkg;

    localparam int unsigned RP_DW = 8;  // pointer / body-length width
    localparam int unsigned RP_CW = 8;  // iteration-count width

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } rp_state_e;

endpackage

// File: rtl/rp_step_counter.sv
// Step index within the current loop iteration. Wraps to zero after the last
// step so the next iteration starts without a bubble.
module rp_step_counter
    import rp_loop_ctrl_pkg::*;
#(
    parameter int unsigned DW = RP_DW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [DW-1:0] i_blen,
    output logic [DW-1:0] o_cnt,
    output logic          o_last_step
);

    logic [DW-1:0] r_cnt;
    logic [DW-1:0] w_last_idx;

    assign w_last_idx  = i_blen - DW'(1);
    assign o_last_step = (r_cnt == w_last_idx);
    assign o_cnt       = r_cnt;

    // Clear has priority; an enabled step on the last index wraps to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (o_last_step) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/rp_loop_ctrl.sv
// Loop-sequencing controller: turns loop commands and processor steps into
// load / increment / rewind strobes for the repeat-pointer register.
module rp_loop_ctrl
    import rp_loop_ctrl_pkg::*;
#(
    parameter int unsigned DW = RP_DW,
    parameter int unsigned CW = RP_CW
) (
    input  logic          Clk,
    input  logic          RSTn,
    input  logic          start,
    input  logic [CW-1:0] count_in,
    input  logic [DW-1:0] body_len,
    input  logic          step_en,
    input  logic          abort,
    output logic          step_rdy,
    output logic          busy,
    output logic          rp_wen,
    output logic          rp_inc,
    output logic          rp_rst,
    output logic          done,
    output logic [CW-1:0] iter_left,
    output logic [DW-1:0] step_cnt
);

    rp_state_e     r_state;
    rp_state_e     w_state_nxt;
    logic [CW-1:0] r_iter;
    logic [CW-1:0] w_iter_nxt;
    logic [DW-1:0] r_blen;
    logic [DW-1:0] w_blen_nxt;

    logic          r_step_rdy;
    logic          r_busy;
    logic          r_wen;
    logic          r_inc;
    logic          r_rst;
    logic          r_done;

    logic          w_wen;
    logic          w_inc;
    logic          w_rst;
    logic          w_done;
    logic          w_cnt_clr;
    logic          w_cnt_en;
    logic          w_last_step;

    rp_step_counter #(
        .DW (DW)
    ) u_step_counter (
        .i_clk       (Clk),
        .i_rst_n     (RSTn),
        .i_clr       (w_cnt_clr),
        .i_en        (w_cnt_en),
        .i_blen      (r_blen),
        .o_cnt       (step_cnt),
        .o_last_step (w_last_step)
    );

    // Next state, latched-value updates and next-cycle strobe values.
    always_comb begin
        w_state_nxt = r_state;
        w_iter_nxt  = r_iter;
        w_blen_nxt  = r_blen;
        w_wen       = 1'b0;
        w_inc       = 1'b0;
        w_rst       = 1'b0;
        w_done      = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_iter_nxt  = '0;
            w_cnt_clr   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_iter_nxt = count_in;
                        w_blen_nxt = body_len;
                        w_cnt_clr  = 1'b1;
                        if ((count_in == '0) || (body_len == '0)) begin
                            w_state_nxt = S_FIN;
                        end else begin
                            w_state_nxt = S_LOAD;
                            w_wen       = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (step_en) begin
                        w_cnt_en = 1'b1;
                        if (!w_last_step) begin
                            w_inc = 1'b1;
                        end else if (r_iter > CW'(1)) begin
                            w_rst      = 1'b1;
                            w_iter_nxt = r_iter - CW'(1);
                        end else begin
                            // Final step: pointer moves past the body.
                            w_inc       = 1'b1;
                            w_iter_nxt  = '0;
                            w_state_nxt = S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, latched command and registered outputs.
    always_ff @(posedge Clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= S_IDLE;
            r_iter     <= '0;
            r_blen     <= '0;
            r_step_rdy <= 1'b0;
            r_busy     <= 1'b0;
            r_wen      <= 1'b0;
            r_inc      <= 1'b0;
            r_rst      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_iter     <= w_iter_nxt;
            r_blen     <= w_blen_nxt;
            r_step_rdy <= (w_state_nxt == S_RUN);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_wen      <= w_wen;
            r_inc      <= w_inc;
            r_rst      <= w_rst;
            r_done     <= w_done;
        end
    end

    assign step_rdy  = r_step_rdy;
    assign busy      = r_busy;
    assign rp_wen    = r_wen;
    assign rp_inc    = r_inc;
    assign rp_rst    = r_rst;
    assign done      = r_done;
    assign iter_left = r_iter;

endmodule

// File: tb/tb_rp_loop_ctrl.sv
// Scoreboard bench for rp_loop_ctrl: directed scenarios plus random traffic,
// checked against a step-total reference model.
module tb_rp_loop_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_FIN  = 3;

    logic          Clk      = 1'b0;
    logic          RSTn     = 1'b0;
    logic          start    = 1'b0;
    logic [CW-1:0] count_in = '0;
    logic [DW-1:0] body_len = '0;
    logic          step_en  = 1'b0;
    logic          abort    = 1'b0;
    logic          step_rdy;
    logic          busy;
    logic          rp_wen;
    logic          rp_inc;
    logic          rp_rst;
    logic          done;
    logic [CW-1:0] iter_left;
    logic [DW-1:0] step_cnt;

    rp_loop_ctrl #(
        .DW (DW),
        .CW (CW)
    ) dut (
        .Clk       (Clk),
        .RSTn      (RSTn),
        .start     (start),
        .count_in  (count_in),
        .body_len  (body_len),
        .step_en   (step_en),
        .abort     (abort),
        .step_rdy  (step_rdy),
        .busy      (busy),
        .rp_wen    (rp_wen),
        .rp_inc    (rp_inc),
        .rp_rst    (rp_rst),
        .done      (done),
        .iter_left (iter_left),
        .step_cnt  (step_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic          rdy;
        logic          bsy;
        logic          wen;
        logic          inc;
        logic          rst;
        logic          dn;
        logic [CW-1:0] iter;
        logic [DW-1:0] scnt;
    } snap_t;

    snap_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: a loop is cnt*bl total steps; k counts steps taken.
    int m_mode = M_IDLE;
    int m_cnt  = 0;
    int m_bl   = 0;
    int m_k    = 0;

    function automatic snap_t model_edge(input logic rst_n, input logic s, input int c,
                                         input int b, input logic e, input logic a);
        snap_t x;
        x = '0;
        if (!rst_n) begin
            m_mode = M_IDLE; m_cnt = 0; m_bl = 0; m_k = 0;
            return x;
        end
        if (a) begin
            m_mode = M_IDLE; m_cnt = 0; m_k = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (s) begin
                    m_cnt = c; m_bl = b; m_k = 0;
                    if (c == 0 || b == 0) m_mode = M_FIN;
                    else begin m_mode = M_LOAD; x.wen = 1'b1; end
                end
                M_LOAD: m_mode = M_RUN;
                M_RUN: if (e) begin
                    m_k = m_k + 1;
                    if (m_k == m_cnt * m_bl) begin x.inc = 1'b1; m_mode = M_FIN; end
                    else if (m_k % m_bl == 0) x.rst = 1'b1;
                    else x.inc = 1'b1;
                end
                default: begin m_mode = M_IDLE; x.dn = 1'b1; end
            endcase
        end
        x.bsy  = (m_mode != M_IDLE);
        x.rdy  = (m_mode == M_RUN);
        x.iter = CW'((m_bl == 0) ? m_cnt : m_cnt - m_k / m_bl);
        x.scnt = DW'((m_bl == 0) ? 0 : m_k % m_bl);
        return x;
    endfunction

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic cyc(input logic s, input int c, input int b, input logic e, input logic a);
        start    = s;
        count_in = CW'(c);
        body_len = DW'(b);
        step_en  = e;
        abort    = a;
        @(posedge Clk);
        exp_q.push_back(model_edge(RSTn, s, c, b, e, a));
        #1;
        start   = 1'b0;
        step_en = 1'b0;
        abort   = 1'b0;
    endtask

    // Monitor: compares the DUT outputs to each expected snapshot away from the edge.
    snap_t m_exp;
    snap_t m_got;
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            m_got = {step_rdy, busy, rp_wen, rp_inc, rp_rst, done, iter_left, step_cnt};
            n_cmp++;
            if (m_got !== m_exp) begin
                n_bad++;
                $display("FAIL outputs @%0t got rdy=%b busy=%b wen=%b inc=%b rst=%b done=%b iter=%0d scnt=%0d exp rdy=%b busy=%b wen=%b inc=%b rst=%b done=%b iter=%0d scnt=%0d",
                         $time, m_got.rdy, m_got.bsy, m_got.wen, m_got.inc, m_got.rst, m_got.dn,
                         m_got.iter, m_got.scnt, m_exp.rdy, m_exp.bsy, m_exp.wen, m_exp.inc,
                         m_exp.rst, m_exp.dn, m_exp.iter, m_exp.scnt);
            end
        end
    end

    // Asynchronous reset between edges: outputs must drop without a clock.
    task automatic async_reset_check();
        @(negedge Clk);
        #1 RSTn = 1'b0;
        #1;
        n_cmp++;
        if ({step_rdy, busy, rp_wen, rp_inc, rp_rst, done, iter_left, step_cnt} !== '0) begin
            n_bad++;
            $display("FAIL async_reset got rdy=%b busy=%b wen=%b inc=%b rst=%b done=%b iter=%0d scnt=%0d exp all zero",
                     step_rdy, busy, rp_wen, rp_inc, rp_rst, done, iter_left, step_cnt);
        end
    endtask

    initial begin
        RSTn = 1'b0;
        repeat (3) cyc(0, 0, 0, 0, 0);
        RSTn = 1'b1;
        repeat (2) cyc(0, 0, 0, 0, 0);

        // Basic loop: 2 iterations of 3 steps, step_en held high.
        cyc(1, 2, 3, 0, 0);
        repeat (12) cyc(0, 0, 0, 1, 0);

        // Degenerate commands.
        cyc(1, 0, 5, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);
        cyc(1, 4, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);

        // Gapped steps, including one during LOAD.
        cyc(1, 1, 2, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);

        // Abort on last step of iteration 1 of 3, together with a start.
        cyc(1, 3, 2, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 5, 5, 1, 1);
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        repeat (5) cyc(0, 0, 0, 1, 0);

        // Start while busy is ignored.
        cyc(1, 2, 2, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 9, 7, 0, 0);
        repeat (8) cyc(0, 0, 0, 1, 0);

        // Reset mid-RUN with count 3.
        cyc(1, 3, 2, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        async_reset_check();
        repeat (2) cyc(0, 0, 0, 1, 0);
        RSTn = 1'b1;
        repeat (3) cyc(0, 0, 0, 1, 0);

        // Width limits: maximum iteration count and maximum body length.
        cyc(1, 255, 1, 0, 0);
        repeat (260) cyc(0, 0, 0, 1, 0);
        cyc(1, 2, 255, 0, 0);
        repeat (515) cyc(0, 0, 0, 1, 0);

        // Random traffic.
        repeat (3000) begin
            cyc($urandom_range(0, 9) == 0, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
        end
        repeat (6) cyc(0, 0, 0, 1, 0);

        @(negedge Clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
